// File: rtl/neighbor_pixel_stream.sv
// neighbor_pixel_stream
//
// Takes one event coordinate (x, y) and a runtime L1 radius. It walks the
// L1 neighbourhood ring by ring and emits one neighbour pixel index per
// cycle over a valid/ready handshake. The candidate order matches the
// fixed 25-entry generator in graph_build:
//   - the centre comes first;
//   - each ring d starts from (d,0) and steps (-1,+1), (-1,-1), (+1,-1),
//     (+1,+1), with d steps of each.
// Out-of-frame neighbours are reported as -1. When skip is set they are
// dropped instead, but they still use one internal cycle.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   in_valid/in_ready  request handshake (one request at a time)
//   in_x, in_y         event coordinate
//   in_radius          requested L1 radius, clamped to MAX_RADIUS
//   in_skip            1 = suppress out-of-frame neighbours
//   out_valid/ready    neighbour beat handshake
//   out_pixel          y*X_PIXEL+x of the neighbour, -1 when out of frame
//   out_seq            canonical index in the full (unskipped) ordering
//   out_dist           L1 distance of the neighbour
//   done               one-cycle pulse after the last candidate is handled
module neighbor_pixel_stream #(
    parameter int X_PIXEL    = 120,
    parameter int Y_PIXEL    = 100,
    parameter int MAX_RADIUS = 3,
    parameter int PIX_W      = $clog2(X_PIXEL*Y_PIXEL)+2,
    parameter int SEQ_W      = $clog2(2*MAX_RADIUS*(MAX_RADIUS+1)+1),
    parameter int R_W        = $clog2(MAX_RADIUS+1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(X_PIXEL)-1:0] in_x,
    input  logic [$clog2(Y_PIXEL)-1:0] in_y,
    input  logic [R_W:0]               in_radius,
    input  logic                       in_skip,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [PIX_W-1:0]    out_pixel,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [R_W-1:0]             out_dist,
    output logic                       done
);

    localparam int XW  = $clog2(X_PIXEL);
    localparam int YW  = $clog2(Y_PIXEL);
    localparam int MW0 = (XW > YW) ? XW : YW;
    localparam int MW  = (MW0 > R_W + 1) ? MW0 : R_W + 1;
    // Coordinate width has one sign bit and one headroom bit, so that
    // x+dx can never wrap.
    localparam int CW  = MW + 2;
    localparam int DW  = R_W + 2;

    localparam logic signed [CW-1:0]    X_LIM    = CW'(X_PIXEL);
    localparam logic signed [CW-1:0]    Y_LIM    = CW'(Y_PIXEL);
    localparam logic signed [PIX_W-1:0] X_MUL    = PIX_W'(X_PIXEL);
    localparam logic [R_W:0]            MAXR_EXT = (R_W+1)'(MAX_RADIUS);
    localparam logic [R_W-1:0]          MAXR     = R_W'(MAX_RADIUS);
    localparam logic [R_W-1:0]          R_ONE    = R_W'(1);
    localparam logic [SEQ_W-1:0]        SEQ_ONE  = SEQ_W'(1);
    localparam logic signed [DW-1:0]    ZERO     = '0;
    localparam logic signed [DW-1:0]    ONE      = DW'(1);

    typedef enum logic {IDLE, WALK} state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [R_W-1:0]          r_q, r_d;
    logic                    skip_q, skip_d;
    logic signed [DW-1:0]    dx_q, dx_d;
    logic signed [DW-1:0]    dy_q, dy_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [PIX_W-1:0] out_pixel_q, out_pixel_d;
    logic [SEQ_W-1:0]        out_seq_q, out_seq_d;
    logic [R_W-1:0]          out_dist_q, out_dist_d;
    logic                    done_q, done_d;

    logic signed [DW-1:0]    d_s;
    logic                    ring_end, last_cand, advance;
    logic signed [DW-1:0]    nxt_dx, nxt_dy;
    logic [R_W-1:0]          nxt_d;
    logic signed [CW-1:0]    c_x, c_y, c_px, c_py;
    logic signed [DW-1:0]    c_dx, c_dy;
    logic                    c_skip, c_inv;
    logic signed [PIX_W-1:0] c_pix;

    assign d_s = $signed({2'b00, out_dist_q});

    // The candidate in the output slot tells us where the next step goes.
    // The current quadrant picks the direction. The ring ends when we are
    // back at (d,0). The centre also matches this with d=0.
    always_comb begin
        ring_end  = (dx_q == d_s) && (dy_q == ZERO);
        last_cand = ring_end && (out_dist_q == r_q);
        nxt_d     = out_dist_q;
        nxt_dx    = dx_q;
        nxt_dy    = dy_q;
        if (ring_end) begin
            nxt_d  = out_dist_q + R_ONE;
            nxt_dx = d_s;
            nxt_dy = ONE;
        end else if (dx_q > ZERO && dy_q >= ZERO) begin
            nxt_dx = dx_q - ONE;
            nxt_dy = dy_q + ONE;
        end else if (dx_q <= ZERO && dy_q > ZERO) begin
            nxt_dx = dx_q - ONE;
            nxt_dy = dy_q - ONE;
        end else if (dx_q < ZERO && dy_q <= ZERO) begin
            nxt_dx = dx_q + ONE;
            nxt_dy = dy_q - ONE;
        end else begin
            nxt_dx = dx_q + ONE;
            nxt_dy = dy_q + ONE;
        end
    end

    // Compute the pixel index and frame check for the candidate about to
    // be loaded. While idle this is the centre of the incoming request.
    always_comb begin
        if (state_q == IDLE) begin
            c_x    = $signed({{(CW-XW){1'b0}}, in_x});
            c_y    = $signed({{(CW-YW){1'b0}}, in_y});
            c_dx   = ZERO;
            c_dy   = ZERO;
            c_skip = in_skip;
        end else begin
            c_x    = $signed({{(CW-XW){1'b0}}, x_q});
            c_y    = $signed({{(CW-YW){1'b0}}, y_q});
            c_dx   = nxt_dx;
            c_dy   = nxt_dy;
            c_skip = skip_q;
        end
        c_px  = c_x + $signed({{(CW-DW){c_dx[DW-1]}}, c_dx});
        c_py  = c_y + $signed({{(CW-DW){c_dy[DW-1]}}, c_dy});
        c_inv = (c_x >= X_LIM) || (c_y >= Y_LIM) ||
                c_px[CW-1] || (c_px >= X_LIM) ||
                c_py[CW-1] || (c_py >= Y_LIM);
        c_pix = c_inv ? '1 : (PIX_W'(c_py) * X_MUL + PIX_W'(c_px));
    end

    // The slot may advance when it is empty or its beat is being taken.
    // An empty slot is either a skipped candidate or an idle state.
    assign advance = (state_q == WALK) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        r_d         = r_q;
        skip_d      = skip_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_seq_d   = out_seq_q;
        out_dist_d  = out_dist_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    state_d     = WALK;
                    x_d         = in_x;
                    y_d         = in_y;
                    r_d         = (in_radius > MAXR_EXT) ? MAXR : in_radius[R_W-1:0];
                    skip_d      = in_skip;
                    dx_d        = ZERO;
                    dy_d        = ZERO;
                    out_seq_d   = '0;
                    out_dist_d  = '0;
                    out_pixel_d = c_pix;
                    out_valid_d = !(c_skip && c_inv);
                end
            end
            WALK: begin
                if (advance) begin
                    if (last_cand) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        dx_d        = nxt_dx;
                        dy_d        = nxt_dy;
                        out_dist_d  = nxt_d;
                        out_seq_d   = out_seq_q + SEQ_ONE;
                        out_pixel_d = c_pix;
                        out_valid_d = !(c_skip && c_inv);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            r_q         <= '0;
            skip_q      <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '1;
            out_seq_q   <= '0;
            out_dist_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            r_q         <= r_d;
            skip_q      <= skip_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_seq_q   <= out_seq_d;
            out_dist_q  <= out_dist_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_seq   = out_seq_q;
    assign out_dist  = out_dist_q;
    assign done      = done_q;

endmodule

// File: tb/tb_neighbor_pixel_stream.sv
// tb_neighbor_pixel_stream
//
// This bench drives directed and random requests into neighbor_pixel_stream.
// It checks every walk cycle against a reference model of the candidate list.
// The model enumerates the list from the ring definition: the centre, then
// for each ring d a start at (d,0), followed by 4d steps whose direction is
// picked by step number.
module tb_neighbor_pixel_stream;

    localparam int XP = 120;
    localparam int YP = 100;
    localparam int MR = 3;
    localparam int PW = 16;
    localparam int SW = 5;
    localparam int RW = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           in_x;
    logic [6:0]           in_y;
    logic [RW:0]          in_radius;
    logic                 in_skip;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] out_pixel;
    logic [SW-1:0]        out_seq;
    logic [RW-1:0]        out_dist;
    logic                 done;

    int n_checks = 0;
    int n_pass   = 0;

    int m_pix[$];
    int m_dist[$];
    bit m_inv[$];

    neighbor_pixel_stream #(
        .X_PIXEL(XP),
        .Y_PIXEL(YP),
        .MAX_RADIUS(MR)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_y(in_y),
        .in_radius(in_radius),
        .in_skip(in_skip),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_seq(out_seq),
        .out_dist(out_dist),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void pushCand(input int x, input int y, input int dx, input int dy, input int d);
        int ax, ay;
        bit inv;
        ax  = x + dx;
        ay  = y + dy;
        inv = (x >= XP) || (y >= YP) || (ax < 0) || (ax >= XP) || (ay < 0) || (ay >= YP);
        m_inv.push_back(inv);
        m_pix.push_back(inv ? -1 : ay * XP + ax);
        m_dist.push_back(d);
    endfunction

    // The full candidate list, indexed by canonical sequence number.
    function automatic void buildModel(input int x, input int y, input int rad);
        int r, cx, cy;
        m_pix.delete();
        m_dist.delete();
        m_inv.delete();
        r = (rad > MR) ? MR : rad;
        pushCand(x, y, 0, 0, 0);
        for (int d = 1; d <= r; d++) begin
            cx = d;
            cy = 0;
            for (int k = 1; k <= 4 * d; k++) begin
                case ((k - 1) / d)
                    0: begin cx = cx - 1; cy = cy + 1; end
                    1: begin cx = cx - 1; cy = cy - 1; end
                    2: begin cx = cx + 1; cy = cy - 1; end
                    default: begin cx = cx + 1; cy = cy + 1; end
                endcase
                pushCand(x, y, cx, cy, d);
            end
        end
    endfunction

    // Called and returns just after a negedge. mode: 0 = always ready,
    // 1 = ready pattern 1,0,0, 2 = random ready. rstAfter >= 0 pulses
    // reset once that many beats have been accepted.
    task automatic applyStimulus(input int x, input int y, input int rad, input int skip,
                                 input int mode, input int rstAfter);
        int idx, cyc, beats, expBeats, n, rdy, expValid;
        buildModel(x, y, rad);
        n = m_pix.size();
        expBeats = 0;
        for (int i = 0; i < n; i++) if (!(skip != 0 && m_inv[i])) expBeats++;
        in_x      = 7'(x);
        in_y      = 7'(y);
        in_radius = 3'(rad);
        in_skip   = (skip != 0);
        in_valid  = 1'b1;
        checkOutput("in_ready_at_request", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        beats = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstAfter >= 0 && beats == rstAfter) begin
                rstn = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                checkOutput("rst_out_valid", int'(out_valid), 0);
                checkOutput("rst_out_pixel", int'(out_pixel), -1);
                checkOutput("rst_out_seq", int'(out_seq), 0);
                checkOutput("rst_out_dist", int'(out_dist), 0);
                checkOutput("rst_done", int'(done), 0);
                rstn = 1'b1;
                @(negedge clk);
                checkOutput("post_rst_in_ready", int'(in_ready), 1);
                checkOutput("post_rst_done", int'(done), 0);
                checkOutput("post_rst_out_valid", int'(out_valid), 0);
                return;
            end
            if (idx == n) begin
                checkOutput("done_pulse", int'(done), 1);
                checkOutput("done_in_ready", int'(in_ready), 1);
                checkOutput("done_out_valid", int'(out_valid), 0);
                checkOutput("beat_count", beats, expBeats);
                return;
            end
            if (cyc > 400) begin
                checkOutput("walk_timeout", idx, n);
                return;
            end
            expValid = (skip != 0 && m_inv[idx]) ? 0 : 1;
            checkOutput("walk_done", int'(done), 0);
            checkOutput("walk_in_ready", int'(in_ready), 0);
            checkOutput("out_valid", int'(out_valid), expValid);
            checkOutput("out_pixel", int'(out_pixel), m_pix[idx]);
            checkOutput("out_seq", int'(out_seq), idx);
            checkOutput("out_dist", int'(out_dist), m_dist[idx]);
            case (mode)
                0: rdy = 1;
                1: rdy = (cyc % 3 == 1) ? 1 : 0;
                default: rdy = int'($urandom_range(0, 1));
            endcase
            out_ready = (rdy != 0);
            if (out_valid && rdy != 0) beats++;
            if (expValid == 0 || rdy != 0) idx++;
        end
    endtask

    task automatic idleCycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput("idle_out_valid", int'(out_valid), 0);
            checkOutput("idle_done", int'(done), 0);
            checkOutput("idle_in_ready", int'(in_ready), 1);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_radius = '0;
        in_skip   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_pixel", int'(out_pixel), -1);
        checkOutput("reset_out_seq", int'(out_seq), 0);
        checkOutput("reset_out_dist", int'(out_dist), 0);
        checkOutput("reset_done", int'(done), 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);

        // Interior radius 1, then corner radius 2 both with and without skip.
        applyStimulus(10, 20, 1, 0, 0, -1);
        idleCycles(2);
        applyStimulus(0, 0, 2, 0, 0, -1);
        idleCycles(1);
        applyStimulus(0, 0, 2, 1, 0, -1);
        idleCycles(1);
        // Stalled walk, clamped radius, centre only, and a fully off-frame x.
        applyStimulus(60, 50, 3, 0, 1, -1);
        idleCycles(1);
        applyStimulus(60, 50, 7, 0, 0, -1);
        idleCycles(1);
        applyStimulus(5, 5, 0, 0, 0, -1);
        idleCycles(1);
        applyStimulus(120, 40, 3, 1, 0, -1);
        // Back-to-back: the second request is presented during the done cycle.
        applyStimulus(119, 99, 2, 0, 2, -1);
        applyStimulus(1, 98, 3, 1, 1, -1);
        idleCycles(1);
        // Reset partway through the walk, then a fresh request.
        applyStimulus(30, 30, 3, 0, 0, 5);
        applyStimulus(30, 30, 2, 0, 0, -1);
        idleCycles(1);

        for (int t = 0; t < 40; t++) begin
            int x, y, rad, skip, mode;
            x    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(115, 127)) : int'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) x = int'($urandom_range(0, 127));
            y    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(95, 127)) : int'($urandom_range(0, 99));
            rad  = int'($urandom_range(0, 7));
            skip = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            applyStimulus(x, y, rad, skip, mode, -1);
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
